hermes_output_arbiter: RTL and testbench

Per-output-port packet arbiter and flit sequencer for the Hermes mesh router used by every `manycore_pe` node. It shares one router output port (EAST, WEST, NORTH, SOUTH or LOCAL) among the five input buffers. Arbitration is round-robin with a lock held for a whole packet. While a packet is locked, the block muxes the granted input's flits onto the output link under credit-based flow control. It releases the port after the last payload flit, using the Hermes packet format: header flit, then size flit, then `size` payload flits.

---
 rtl/hermes_output_arbiter.sv | 137 +++++++++++++
 tb/tb_hermes_output_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_output_arbiter.sv
// Hermes router output-port arbiter: round-robin selection among the input
// buffers, packet lock from header to last payload flit, and a credit-gated
// flit mux onto the output link.
module hermes_output_arbiter #(
    parameter int FLIT_WIDTH = 32,
    parameter int NPORTS     = 5,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NPORTS-1:0]            req_i,
    input  logic [NPORTS-1:0]            rx_i,
    input  logic [NPORTS*FLIT_WIDTH-1:0] data_i,
    output logic [NPORTS-1:0]            ack_o,
    output logic [NPORTS-1:0]            grant_o,
    output logic                         tx_o,
    output logic [FLIT_WIDTH-1:0]        data_o,
    input  logic                         credit_i,
    output logic                         busy_o
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NPORTS-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;

    logic                  sel_valid;
    logic [PTR_W-1:0]      sel_idx;
    logic                  xfer;
    logic [FLIT_WIDTH-1:0] data_sel;
    logic [FLIT_WIDTH-1:0] flit_arr [NPORTS];

    // Unflatten the input flit bus so the granted slice can be picked by index.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_slice
            assign flit_arr[gi] = data_i[gi*FLIT_WIDTH +: FLIT_WIDTH];
        end
    endgenerate

    // Round-robin search: first requester found scanning cyclically from ptr+1.
    // Scanning from the far end down lets the nearest hit win the last assignment.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NPORTS;
            if (req_i[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = idx[PTR_W-1:0];
            end
        end
    end

    // Output mux: while locked, ptr_q names the granted port.
    always_comb begin
        busy_o   = (state_q != IDLE);
        data_sel = busy_o ? flit_arr[ptr_q] : '0;
        tx_o     = busy_o & rx_i[ptr_q];
        xfer     = tx_o & credit_i;
        data_o   = data_sel;
        ack_o    = grant_q & {NPORTS{xfer}};
        grant_o  = grant_q;
    end

    // Next-state logic: arbitrate in IDLE, then walk header/size/payload flits.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = NPORTS'(1) << sel_idx;
                    ptr_d   = sel_idx;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    remaining_d = data_sel[SIZE_WIDTH-1:0];
                    if (data_sel[SIZE_WIDTH-1:0] == '0) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    remaining_d = remaining_q - SIZE_WIDTH'(1);
                    if (remaining_q == SIZE_WIDTH'(1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset parks the pointer on the last port so port 0 is searched first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= PTR_W'(NPORTS - 1);
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_hermes_output_arbiter.sv
// Directed bench for hermes_output_arbiter with a flit scoreboard.
module tb_hermes_output_arbiter;

    localparam int FW = 32;
    localparam int NP = 5;
    localparam int SW = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    req_i;
    logic [NP-1:0]    rx_i;
    logic [NP*FW-1:0] data_i;
    logic [NP-1:0]    ack_o;
    logic [NP-1:0]    grant_o;
    logic             tx_o;
    logic [FW-1:0]    data_o;
    logic             credit_i;
    logic             busy_o;

    int tests = 0;
    int fails = 0;

    logic [FW-1:0] exp_data_q [$];
    logic [NP-1:0] exp_ack_q  [$];

    hermes_output_arbiter #(.FLIT_WIDTH(FW), .NPORTS(NP), .SIZE_WIDTH(SW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req_i),
        .rx_i     (rx_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .grant_o  (grant_o),
        .tx_o     (tx_o),
        .data_o   (data_o),
        .credit_i (credit_i),
        .busy_o   (busy_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score any consumed flit, cross the rising edge, return at the falling edge.
    task automatic tick(output bit acked);
        logic [FW-1:0] ed;
        logic [NP-1:0] ea;
        #1;
        acked = (ack_o != '0);
        if (acked) begin
            if (exp_data_q.size() == 0) begin
                check("spurious_ack", 64'(ack_o), 64'd0);
            end else begin
                ed = exp_data_q.pop_front();
                ea = exp_ack_q.pop_front();
                check("flit_data", 64'(data_o), 64'(ed));
                check("flit_ack", 64'(ack_o), 64'(ea));
                $display("[TB] flit %08h acked on port mask %05b", data_o, ack_o);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Present a flit on a port and wait (bounded) until it is consumed.
    task automatic xfer(input int port, input logic [FW-1:0] flit, output int n);
        bit acked;
        rx_i[port] = 1'b1;
        data_i[port*FW +: FW] = flit;
        exp_data_q.push_back(flit);
        exp_ack_q.push_back(NP'(1) << port);
        n = 0;
        acked = 1'b0;
        while (!acked && n < 50) begin
            tick(acked);
            n++;
        end
        check("xfer_done", 64'(acked), 64'd1);
    endtask

    // Raise requests and wait (bounded) for a grant.
    task automatic arbitrate(input logic [NP-1:0] reqs, output int n);
        bit dummy;
        req_i = reqs;
        n = 0;
        while (grant_o == '0 && n < 20) begin
            tick(dummy);
            n++;
        end
    endtask

    initial begin
        int n;
        bit dummy;
        reset    = 1'b1;
        req_i    = '0;
        rx_i     = '0;
        data_i   = '0;
        credit_i = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_tx", 64'(tx_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_ack", 64'(ack_o), 64'd0);

        // Round-robin with all five requesting, size-1 packets.
        for (int i = 0; i < 6; i++) begin
            int p;
            p = i % NP;
            arbitrate(5'b11111, n);
            check("rr_arb_latency", 64'(n), 64'd1);
            check("rr_grant", 64'(grant_o), 64'(NP'(1) << p));
            xfer(p, 32'h1000_0000 + 32'(p), n);
            xfer(p, 32'd1, n);
            check("rr_busy_mid", 64'(busy_o), 64'd1);
            xfer(p, 32'hCAFE_0000 + 32'(i), n);
            check("rr_release", 64'(grant_o), 64'd0);
            rx_i = '0;
        end
        req_i = '0;

        // Single LOCAL packet, size 3, continuous flow.
        arbitrate(5'b10000, n);
        check("local_arb_latency", 64'(n), 64'd1);
        check("local_grant", 64'(grant_o), 64'b10000);
        req_i = '0;
        xfer(4, 32'h0000_0101, n); check("local_hdr_cycles", 64'(n), 64'd1);
        xfer(4, 32'd3, n);         check("local_size_cycles", 64'(n), 64'd1);
        xfer(4, 32'hAAAA_0001, n); check("local_p0_cycles", 64'(n), 64'd1);
        xfer(4, 32'hAAAA_0002, n); check("local_p1_cycles", 64'(n), 64'd1);
        check("local_busy_before_last", 64'(busy_o), 64'd1);
        xfer(4, 32'hAAAA_0003, n); check("local_p2_cycles", 64'(n), 64'd1);
        check("local_busy_after", 64'(busy_o), 64'd0);
        check("local_grant_after", 64'(grant_o), 64'd0);
        rx_i = '0;

        // Zero-size packet on NORTH.
        arbitrate(5'b00100, n);
        check("zero_grant", 64'(grant_o), 64'b00100);
        req_i = '0;
        xfer(2, 32'h0000_0202, n);
        xfer(2, 32'hFFFF_0000, n);
        check("zero_release_busy", 64'(busy_o), 64'd0);
        check("zero_release_grant", 64'(grant_o), 64'd0);
        rx_i = '0;

        // Size-2 packet on SOUTH with a 2-cycle bubble after the header.
        arbitrate(5'b01000, n);
        check("bub_grant", 64'(grant_o), 64'b01000);
        req_i = '0;
        xfer(3, 32'h0000_0303, n);
        rx_i[3] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1;
            check("bub_tx", 64'(tx_o), 64'd0);
            check("bub_ack", 64'(ack_o), 64'd0);
            check("bub_grant_hold", 64'(grant_o), 64'b01000);
            tick(dummy);
        end
        xfer(3, 32'd2, n);
        xfer(3, 32'hBBBB_0001, n);
        check("bub_busy_mid", 64'(busy_o), 64'd1);
        xfer(3, 32'hBBBB_0002, n);
        check("bub_release", 64'(busy_o), 64'd0);
        rx_i = '0;

        // Back-pressure mid-payload on WEST, size 4.
        arbitrate(5'b00010, n);
        check("bp_grant", 64'(grant_o), 64'b00010);
        req_i = '0;
        xfer(1, 32'h0000_0404, n);
        xfer(1, 32'd4, n);
        xfer(1, 32'hDDDD_0001, n);
        credit_i = 1'b0;
        rx_i[1] = 1'b1;
        data_i[1*FW +: FW] = 32'hDDDD_0002;
        for (int b = 0; b < 4; b++) begin
            #1;
            check("bp_ack", 64'(ack_o), 64'd0);
            check("bp_data", 64'(data_o), 64'hDDDD_0002);
            check("bp_grant_hold", 64'(grant_o), 64'b00010);
            check("bp_remaining", 64'(dut.remaining_q), 64'd3);
            tick(dummy);
        end
        credit_i = 1'b1;
        xfer(1, 32'hDDDD_0002, n); check("bp_resume_cycles", 64'(n), 64'd1);
        xfer(1, 32'hDDDD_0003, n);
        check("bp_busy_before_last", 64'(busy_o), 64'd1);
        xfer(1, 32'hDDDD_0004, n);
        check("bp_release", 64'(busy_o), 64'd0);
        rx_i = '0;

        // Reset in PAYLOAD with 5 flits still owed.
        arbitrate(5'b00001, n);
        check("rstm_grant", 64'(grant_o), 64'b00001);
        req_i = '0;
        xfer(0, 32'h0000_0505, n);
        xfer(0, 32'd7, n);
        xfer(0, 32'hEEEE_0001, n);
        xfer(0, 32'hEEEE_0002, n);
        check("rstm_remaining", 64'(dut.remaining_q), 64'd5);
        credit_i = 1'b0;
        reset = 1'b1;
        tick(dummy);
        reset = 1'b0;
        credit_i = 1'b1;
        #1;
        check("rstm_grant_clear", 64'(grant_o), 64'd0);
        check("rstm_busy_clear", 64'(busy_o), 64'd0);
        check("rstm_tx_clear", 64'(tx_o), 64'd0);
        check("rstm_ack_clear", 64'(ack_o), 64'd0);
        rx_i = '0;
        arbitrate(5'b00110, n);
        check("rstm_rearb_grant", 64'(grant_o), 64'b00010);
        req_i = '0;

        check("scoreboard_empty", 64'(exp_data_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
